// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address generation, pipeline squash, return stack
// and single-level interrupt entry/exit with sticky stop/error reporting.
module pc_seq #(
   parameter int unsigned       ADDR_W      = 12,
   parameter int unsigned       STACK_DEPTH = 8,
   parameter int unsigned       KILL_DEPTH  = 2,
   parameter logic [ADDR_W-1:0] INT_VECTOR  = ADDR_W'('h004)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             pause,
   input  logic                             goto,
   input  logic                             call,
   input  logic                             skip,
   input  logic                             ret,
   input  logic                             reti,
   input  logic [ADDR_W-1:0]                goto_addr,
   input  logic                             irq,
   input  logic                             ei,
   input  logic                             di,
   output logic [ADDR_W-1:0]                pc_out,
   output logic                             kill,
   output logic                             irq_ack,
   output logic                             stopped,
   output logic                             error,
   output logic [1:0]                       error_code,
   output logic                             int_en,
   output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);

   localparam int unsigned LVL_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);
   localparam int unsigned KCNT_W = $clog2(KILL_DEPTH + 1);

   localparam logic [1:0] ERR_CALL_OVF = 2'b01;
   localparam logic [1:0] ERR_IRQ_OVF  = 2'b10;
   localparam logic [1:0] ERR_RETI_UNF = 2'b11;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [KCNT_W-1:0] kcnt_q, kcnt_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              int_en_q, int_en_d;
   logic              irq_ack_q, irq_ack_d;
   logic              stopped_q, stopped_d;
   logic              error_q, error_d;
   logic [1:0]        error_code_q, error_code_d;

   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic              push;
   logic [ADDR_W-1:0] push_data;
   logic [ADDR_W-1:0] top;
   logic              advance, full, empty, killing;

   assign advance = !pause && !stopped_q;
   assign killing = (kcnt_q != '0);
   assign full    = (level_q == LVL_W'(STACK_DEPTH));
   assign empty   = (level_q == '0);
   // Combinational top-of-stack read lets ret/reti finish in one cycle.
   assign top     = empty ? '0 : stack_q[IDX_W'(level_q - LVL_W'(1))];

   always_comb begin
      pc_d         = pc_q;
      kcnt_d       = kcnt_q;
      level_d      = level_q;
      int_en_d     = int_en_q;
      irq_ack_d    = 1'b0;
      stopped_d    = stopped_q;
      error_d      = error_q;
      error_code_d = error_code_q;
      push         = 1'b0;
      push_data    = pc_q;

      if (advance) begin
         if (di) begin
            int_en_d = 1'b0;
         end else if (ei) begin
            int_en_d = 1'b1;
         end

         if (killing) begin
            pc_d   = pc_q + ADDR_W'(1);
            kcnt_d = kcnt_q - KCNT_W'(1);
         end else if (irq && int_en_q) begin
            if (full) begin
               stopped_d    = 1'b1;
               error_d      = 1'b1;
               error_code_d = ERR_IRQ_OVF;
            end else begin
               // Resume at the oldest instruction squashed by this entry.
               push      = 1'b1;
               push_data = pc_q - ADDR_W'(KILL_DEPTH);
               level_d   = level_q + LVL_W'(1);
               pc_d      = INT_VECTOR;
               int_en_d  = 1'b0;
               kcnt_d    = KCNT_W'(KILL_DEPTH);
               irq_ack_d = 1'b1;
            end
         end else if (skip) begin
            pc_d   = pc_q + ADDR_W'(1);
            kcnt_d = KCNT_W'(1);
         end else if (goto || call) begin
            if (call && full) begin
               stopped_d    = 1'b1;
               error_d      = 1'b1;
               error_code_d = ERR_CALL_OVF;
            end else begin
               if (call) begin
                  push    = 1'b1;
                  level_d = level_q + LVL_W'(1);
               end
               pc_d   = goto_addr;
               kcnt_d = KCNT_W'(KILL_DEPTH);
            end
         end else if (reti) begin
            if (empty) begin
               stopped_d    = 1'b1;
               error_d      = 1'b1;
               error_code_d = ERR_RETI_UNF;
            end else begin
               pc_d     = top;
               level_d  = level_q - LVL_W'(1);
               kcnt_d   = KCNT_W'(KILL_DEPTH);
               int_en_d = 1'b1;
            end
         end else if (ret) begin
            if (empty) begin
               stopped_d = 1'b1;
            end else begin
               pc_d    = top;
               level_d = level_q - LVL_W'(1);
               kcnt_d  = KCNT_W'(KILL_DEPTH);
            end
         end else begin
            pc_d = pc_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= '0;
         kcnt_q       <= KCNT_W'(KILL_DEPTH);
         level_q      <= '0;
         int_en_q     <= 1'b0;
         irq_ack_q    <= 1'b0;
         stopped_q    <= 1'b0;
         error_q      <= 1'b0;
         error_code_q <= 2'b00;
      end else begin
         pc_q         <= pc_d;
         kcnt_q       <= kcnt_d;
         level_q      <= level_d;
         int_en_q     <= int_en_d;
         irq_ack_q    <= irq_ack_d;
         stopped_q    <= stopped_d;
         error_q      <= error_d;
         error_code_q <= error_code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         stack_q[IDX_W'(level_q)] <= push_data;
      end
   end

   assign pc_out      = pc_q;
   assign kill        = killing;
   assign irq_ack     = irq_ack_q;
   assign stopped     = stopped_q;
   assign error       = error_q;
   assign error_code  = error_code_q;
   assign int_en      = int_en_q;
   assign stack_level = level_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: vector table for the main sequences, hand-written
// sequences for return-stack overflow on call and on interrupt entry.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        reset, pause, goto, call, skip, ret, reti, irq, ei, di;
   logic [11:0] goto_addr;
   logic [11:0] pc_out;
   logic        kill, irq_ack, stopped, error, int_en;
   logic [1:0]  error_code;
   logic [3:0]  stack_level;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] C_RST = 10'b10_0000_0000;
   localparam logic [9:0] C_PSE = 10'b01_0000_0000;
   localparam logic [9:0] C_GTO = 10'b00_1000_0000;
   localparam logic [9:0] C_CAL = 10'b00_0100_0000;
   localparam logic [9:0] C_SKP = 10'b00_0010_0000;
   localparam logic [9:0] C_RET = 10'b00_0001_0000;
   localparam logic [9:0] C_RTI = 10'b00_0000_1000;
   localparam logic [9:0] C_IRQ = 10'b00_0000_0100;
   localparam logic [9:0] C_EI  = 10'b00_0000_0010;
   localparam logic [9:0] C_DI  = 10'b00_0000_0001;

   typedef struct {
      logic [9:0]  ctl;
      logic [11:0] addr;
      int          n;
      logic [11:0] pc;
      logic        kill;
      int          lvl;
      logic        ie;
      logic        ack;
      logic        st;
      logic        err;
      logic [1:0]  code;
   } vec_t;

   vec_t vecs[$];

   pc_seq dut (
      .clk        (clk),
      .reset      (reset),
      .pause      (pause),
      .goto       (goto),
      .call       (call),
      .skip       (skip),
      .ret        (ret),
      .reti       (reti),
      .goto_addr  (goto_addr),
      .irq        (irq),
      .ei         (ei),
      .di         (di),
      .pc_out     (pc_out),
      .kill       (kill),
      .irq_ack    (irq_ack),
      .stopped    (stopped),
      .error      (error),
      .error_code (error_code),
      .int_en     (int_en),
      .stack_level(stack_level)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [9:0] ctl, input logic [11:0] a);
      reset     = ctl[9];
      pause     = ctl[8];
      goto      = ctl[7];
      call      = ctl[6];
      skip      = ctl[5];
      ret       = ctl[4];
      reti      = ctl[3];
      irq       = ctl[2];
      ei        = ctl[1];
      di        = ctl[0];
      goto_addr = a;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [9:0] ctl, input logic [11:0] addr, input int n,
                               input logic [11:0] pc, input logic k, input int lvl,
                               input logic ie, input logic ack, input logic st,
                               input logic err, input logic [1:0] code);
      vec_t v;
      v.ctl = ctl; v.addr = addr; v.n = n; v.pc = pc; v.kill = k; v.lvl = lvl;
      v.ie = ie; v.ack = ack; v.st = st; v.err = err; v.code = code;
      vecs.push_back(v);
   endfunction

   // Fill the stack with eight calls, then overflow it with a ninth call or an interrupt.
   task automatic overflow(input bit use_irq);
      string tag;
      tag = use_irq ? "irq_ovf" : "call_ovf";
      drive(C_RST, 12'h000); step();
      drive(C_EI, 12'h000);  step();
      drive('0, 12'h000);    step();
      chk({tag, " start pc"}, 32'(pc_out), 32'h2);
      for (int i = 0; i < 8; i++) begin
         drive(C_CAL, 12'((i + 1) * 100)); step();
         chk($sformatf("%s call%0d pc", tag, i), 32'(pc_out), 32'((i + 1) * 100));
         chk($sformatf("%s call%0d lvl", tag, i), 32'(stack_level), 32'(i + 1));
         drive('0, 12'h000); step(); step();
      end
      if (use_irq) drive(C_IRQ, 12'h000);
      else drive(C_CAL, 12'd900);
      step();
      drive('0, 12'h000);
      chk({tag, " stopped"}, 32'(stopped), 32'h1);
      chk({tag, " error"}, 32'(error), 32'h1);
      chk({tag, " code"}, 32'(error_code), use_irq ? 32'h2 : 32'h1);
      chk({tag, " pc"}, 32'(pc_out), 32'd802);
      chk({tag, " lvl"}, 32'(stack_level), 32'd8);
      chk({tag, " ack"}, 32'(irq_ack), 32'h0);
      step();
      chk({tag, " frozen pc"}, 32'(pc_out), 32'd802);
      drive(C_RST | C_PSE, 12'h000); step();
      chk({tag, " rst pc"}, 32'(pc_out), 32'h0);
      chk({tag, " rst kill"}, 32'(kill), 32'h1);
      chk({tag, " rst lvl"}, 32'(stack_level), 32'h0);
      chk({tag, " rst st"}, 32'(stopped), 32'h0);
      chk({tag, " rst err"}, 32'(error), 32'h0);
      chk({tag, " rst code"}, 32'(error_code), 32'h0);
      chk({tag, " rst ie"}, 32'(int_en), 32'h0);
      drive('0, 12'h000);
   endtask

   initial begin
      drive(C_RST, 12'h000);

      //  ctl            addr    n  pc      k  lvl ie ack st err code
      add(C_RST,         12'h0,  1, 12'h000, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h001, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h002, 0, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  8, 12'h00A, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_CAL,         12'd40, 1, 12'h028, 1, 1, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h029, 1, 1, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h02A, 0, 1, 0, 0, 0, 0, 2'd0);
      add(C_RET,         12'h0,  1, 12'h00A, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  2, 12'h00C, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_SKP | C_GTO, 12'd100,1, 12'h00D, 1, 0, 0, 0, 0, 0, 2'd0);
      add(C_GTO,         12'd100,1, 12'h00E, 0, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h00F, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_EI | C_IRQ,  12'h0,  1, 12'h010, 0, 0, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  4, 12'h014, 0, 0, 1, 0, 0, 0, 2'd0);
      add(C_IRQ,         12'h0,  1, 12'h004, 1, 1, 0, 1, 0, 0, 2'd0);
      add(C_IRQ,         12'h0,  1, 12'h005, 1, 1, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h006, 0, 1, 0, 0, 0, 0, 2'd0);
      add(C_RTI,         12'h0,  1, 12'h012, 1, 0, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  2, 12'h014, 0, 0, 1, 0, 0, 0, 2'd0);
      add(C_DI,          12'h0,  1, 12'h015, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_RET,         12'h0,  1, 12'h015, 0, 0, 0, 0, 1, 0, 2'd0);
      add(C_GTO,         12'd50, 1, 12'h015, 0, 0, 0, 0, 1, 0, 2'd0);
      add(C_RST,         12'h0,  1, 12'h000, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  2, 12'h002, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_GTO,         12'hFFE,1, 12'hFFE, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'hFFF, 1, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h000, 0, 0, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h001, 0, 0, 0, 0, 0, 0, 2'd0);
      add(C_RTI,         12'h0,  1, 12'h001, 0, 0, 0, 0, 1, 1, 2'd3);
      add(C_RST | C_PSE, 12'h0,  1, 12'h000, 1, 0, 0, 0, 0, 0, 2'd0);
      add(C_EI,          12'h0,  1, 12'h001, 1, 0, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h002, 0, 0, 1, 0, 0, 0, 2'd0);
      add(C_CAL,         12'd60, 1, 12'h03C, 1, 1, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  2, 12'h03E, 0, 1, 1, 0, 0, 0, 2'd0);
      add(C_PSE | C_IRQ, 12'h0,  5, 12'h03E, 0, 1, 1, 0, 0, 0, 2'd0);
      add(C_IRQ,         12'h0,  1, 12'h004, 1, 2, 0, 1, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h005, 1, 2, 0, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h006, 0, 2, 0, 0, 0, 0, 2'd0);
      add(C_RTI,         12'h0,  1, 12'h03C, 1, 1, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  2, 12'h03E, 0, 1, 1, 0, 0, 0, 2'd0);
      add(C_RET,         12'h0,  1, 12'h002, 1, 0, 1, 0, 0, 0, 2'd0);
      add(C_PSE,         12'h0,  3, 12'h002, 1, 0, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h003, 1, 0, 1, 0, 0, 0, 2'd0);
      add('0,            12'h0,  1, 12'h004, 0, 0, 1, 0, 0, 0, 2'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].ctl, vecs[i].addr);
         repeat (vecs[i].n) step();
         chk($sformatf("v%0d pc", i),   32'(pc_out),      32'(vecs[i].pc));
         chk($sformatf("v%0d kill", i), 32'(kill),        32'(vecs[i].kill));
         chk($sformatf("v%0d lvl", i),  32'(stack_level), 32'(vecs[i].lvl));
         chk($sformatf("v%0d ie", i),   32'(int_en),      32'(vecs[i].ie));
         chk($sformatf("v%0d ack", i),  32'(irq_ack),     32'(vecs[i].ack));
         chk($sformatf("v%0d st", i),   32'(stopped),     32'(vecs[i].st));
         chk($sformatf("v%0d err", i),  32'(error),       32'(vecs[i].err));
         chk($sformatf("v%0d code", i), 32'(error_code),  32'(vecs[i].code));
      end

      overflow(1'b0);
      overflow(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Parameters
REQ-001 SHALL provide ADDR_W, default 12, width of program addresses.
REQ-002 SHALL provide STACK_DEPTH, default 8, return-stack entries (>=2).
REQ-003 SHALL provide KILL_DEPTH, default 2, pipeline stages between fetch and execute (>=1).
REQ-004 SHALL provide INT_VECTOR, default 12'h004, interrupt entry address (ADDR_W bits).

Interface
REQ-005 SHALL have: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have: pause  in  1  freezes all state while high.
REQ-008 SHALL have: goto, call, skip, ret, reti  in  1 each  control requests from execute stage.
REQ-009 SHALL have: goto_addr  in  ADDR_W  jump/call target.
REQ-010 SHALL have: irq  in  1 (level interrupt request); ei, di  in  1 each (set/clear interrupt enable).
REQ-011 SHALL have: pc_out  out  ADDR_W  fetch address.
REQ-012 SHALL have: kill  out  1  squash the instruction now in execute.
REQ-013 SHALL have: irq_ack  out  1  one-cycle pulse on interrupt entry.
REQ-014 SHALL have: stopped, error  out  1 each; error_code  out  2 (00 none, 01 call overflow, 10 irq overflow, 11 reti underflow).
REQ-015 SHALL have: int_en  out  1; stack_level  out  clog2(STACK_DEPTH+1).

Function
REQ-016 Kill counter kcnt (0..KILL_DEPTH); kill SHALL equal (kcnt != 0).
REQ-017 A cycle "advances" when !pause && !stopped; otherwise all registers hold and irq_ack=0.
REQ-018 On advance with kill=1, control inputs SHALL be ignored, pc<=pc+1, kcnt<=kcnt-1.
REQ-019 On advance with kill=0, exactly one action SHALL occur, priority: interrupt > skip > goto/call > reti > ret > increment.
REQ-020 Interrupt: irq && int_en -> push (pc - KILL_DEPTH) mod 2^ADDR_W, pc<=INT_VECTOR, int_en<=0, kcnt<=KILL_DEPTH, irq_ack<=1.
REQ-021 Skip: pc<=pc+1, kcnt<=1.
REQ-022 Goto: pc<=goto_addr, kcnt<=KILL_DEPTH; with call additionally push current pc.
REQ-023 Ret/reti with stack non-empty: pc<=top, pop, kcnt<=KILL_DEPTH; reti also sets int_en<=1.
REQ-024 Ret with stack empty: stopped<=1, error stays 0 (clean program exit), pc holds.
REQ-025 Reti with stack empty: stopped<=1, error<=1, error_code<=11.
REQ-026 Push when stack_level==STACK_DEPTH: no push, pc holds, stopped<=1, error<=1, error_code<=01 (call) or 10 (irq), irq_ack stays 0.
REQ-027 Increment: pc<=pc+1, wrapping modulo 2^ADDR_W.
REQ-028 ei/di SHALL apply on any advance cycle (di wins if both); interrupt entry/reti update to int_en overrides ei/di same cycle.
REQ-029 Interrupt SHALL be evaluated after int_en updates of the prior cycle only (ei takes effect next cycle).
REQ-030 stopped and error SHALL be sticky until reset; stack_level SHALL track pushes/pops exactly.
REQ-031 Stack read SHALL be combinational on top entry so ret completes in one cycle.

Reset
REQ-032 On reset: pc_out=0, kcnt=KILL_DEPTH (kill=1), stack empty, stack_level=0, int_en=0, irq_ack=0, stopped=0, error=0, error_code=00.
REQ-033 Reset SHALL override pause and stopped and abort any in-progress action, mid-call or mid-interrupt.

Verification
REQ-034 Reset, no requests: kill high 2 cycles, pc_out 0,1,2,3...; at pc 12'hFFF next is 12'h000.
REQ-035 At pc=10 call goto_addr=40 -> pc 40, kill 2 cycles, stack_level 1; later ret -> pc 10, stack_level 0; second ret -> stopped=1, error=0.
REQ-036 ei, irq at pc=20 -> irq_ack pulse, pc 4, int_en 0, pushed 18; reti -> pc 18, int_en 1.
REQ-037 Nine nested calls (depth 8) -> ninth: stopped=1, error=1, error_code=01, pc frozen; reset clears all.
REQ-038 skip with goto same cycle -> pc+1, kill exactly 1 cycle, goto ignored; goto while kill=1 ignored.
REQ-039 pause high 5 cycles mid-sequence -> pc_out, kill, stack_level unchanged; irq held during pause taken on first advance.
